// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative 32-bit signed multiply / divide unit with HI/LO result registers.
//   Multiply: radix-2 Booth, one step per clock on a 65-bit work register
//   {acc, multiplier, q-1}.
//   Divide: restoring division on operand magnitudes; the quotient and
//   remainder signs are applied as the results are written.
//   The sequence runs 32 steps, then HI/LO are written and done is pulsed.
//   A divide with divisor 0 skips the steps: div_zero and done pulse, and
//   HI/LO keep their old values.
//
// Ports
//   clock    : system clock, rising edge
//   reset    : asynchronous active-low reset
//   start    : start request, sampled only in IDLE
//   op       : 0 = signed multiply, 1 = signed divide
//   a_in     : multiplicand / dividend (two's complement)
//   b_in     : multiplier / divisor (two's complement)
//   hi_out   : product[63:32] / remainder (sign of dividend)
//   lo_out   : product[31:0]  / quotient (truncated toward zero)
//   busy     : operation in progress
//   done     : one-cycle completion pulse, HI/LO valid
//   div_zero : one-cycle pulse with done when the divisor was 0
// -----------------------------------------------------------------------------
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic        op_q, a_neg, b_neg, dz_q;
  logic [31:0] opnd;       // multiplicand (mult) or divisor magnitude (div)
  logic [64:0] work;       // mult: {acc, multiplier, q-1}; div: {0, rem, quo}
  logic [64:0] work_nx;    // work after one step
  logic [32:0] booth_sum;
  logic [32:0] div_shift;  // remainder shifted left with next dividend bit
  logic [31:0] div_diff;
  logic [31:0] abs_a, abs_b;
  logic [31:0] res_hi, res_lo;
  logic        accept, last_step;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == RUN) && (cnt == 6'd31);
  assign abs_a     = a_in[31] ? -a_in : a_in;
  assign abs_b     = b_in[31] ? -b_in : b_in;

  // State register.
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples its inputs from the same pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and FSM outputs.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    div_zero = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = (op && (b_in == '0)) ? FINISH : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 6'd31) state_nx = FINISH;
      end
      FINISH: begin
        done     = 1'b1;
        div_zero = dz_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One Booth or restoring-division step.
  always_comb begin
    booth_sum = {work[64], work[64:33]};
    unique case (work[1:0])
      2'b01:   booth_sum = {work[64], work[64:33]} + {opnd[31], opnd};
      2'b10:   booth_sum = {work[64], work[64:33]} - {opnd[31], opnd};
      default: booth_sum = {work[64], work[64:33]};
    endcase

    div_shift = {work[63:32], work[31]};
    div_diff  = div_shift[31:0] - opnd;

    if (op_q) begin
      // The remainder stays below the divisor, so it always fits 32 bits.
      if (div_shift >= {1'b0, opnd}) work_nx = {1'b0, div_diff, work[30:0], 1'b1};
      else                           work_nx = {1'b0, div_shift[31:0], work[30:0], 1'b0};
    end else begin
      // Arithmetic shift of the 33-bit exact sum keeps the correct sign even
      // when the multiplicand is 0x80000000.
      work_nx = {booth_sum, work[32:1]};
    end
  end

  // Final results, taken from the last step's output.
  always_comb begin
    if (op_q) begin
      res_lo = (a_neg ^ b_neg) ? -work_nx[31:0]  : work_nx[31:0];
      res_hi = a_neg           ? -work_nx[63:32] : work_nx[63:32];
    end else begin
      res_hi = work_nx[64:33];
      res_lo = work_nx[32:1];
    end
  end

  // Datapath and result registers.
  // NOTE: every datapath register is cleared by reset so an aborted
  // operation leaves nothing behind for the next one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      op_q   <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      dz_q   <= 1'b0;
      opnd   <= '0;
      work   <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else if (accept) begin
      cnt   <= '0;
      op_q  <= op;
      dz_q  <= op && (b_in == '0);
      a_neg <= op && a_in[31];
      b_neg <= op && b_in[31];
      if (op) begin
        opnd <= abs_b;
        work <= {1'b0, 32'd0, abs_a};
      end else begin
        opnd <= a_in;
        work <= {32'd0, b_in, 1'b0};
      end
    end else if (state == RUN) begin
      work <= work_nx;
      cnt  <= cnt + 6'd1;
      if (last_step) begin
        hi_out <= res_hi;
        lo_out <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed self-checking bench for mult_div_unit. Inputs change and outputs
//   are sampled 1 time unit after each rising edge. Latency is counted in
//   rising edges including the accepting edge.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in, b_in;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero;

  int passed = 0;
  int total  = 0;

  mult_div_unit dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one operation and wait (bounded) for done. When disturb is set,
  // start is re-pulsed with other operands 5 and 20 cycles into the run.
  // Operands are scrambled right after acceptance in every case.
  task automatic run_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                        input bit disturb, output int lat, output logic busy_seen);
    op    = op_v;
    a_in  = a_v;
    b_in  = b_v;
    start = 1'b1;
    @(posedge clock); #1;
    lat       = 1;
    busy_seen = busy;
    start     = 1'b0;
    a_in      = $urandom;
    b_in      = $urandom;
    while (!done && lat < 40) begin
      if (disturb && (lat == 5 || lat == 20)) begin
        start = 1'b1;
        op    = ~op_v;
        a_in  = $urandom;
        b_in  = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  int   lat;
  logic bsy;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #12;
    check("rst_hi",   hi_out,   64'h0);
    check("rst_lo",   lo_out,   64'h0);
    check("rst_busy", busy,     64'h0);
    check("rst_done", done,     64'h0);
    check("rst_dz",   div_zero, 64'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // 7 * -3 = -21
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, lat, bsy);
    check("mul1_busy", bsy, 64'h1);
    check("mul1_lat",  lat, 64'd33);
    check("mul1_hi",   hi_out, 64'hFFFF_FFFF);
    check("mul1_lo",   lo_out, 64'hFFFF_FFEB);
    check("mul1_dz",   div_zero, 64'h0);
    check("mul1_fin_busy", busy, 64'h0);
    @(posedge clock); #1;
    check("mul1_done_pulse", done, 64'h0);

    // (-2^31) * (-2^31) = 2^62
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, bsy);
    check("mul2_hi", hi_out, 64'h4000_0000);
    check("mul2_lo", lo_out, 64'h0);
    @(posedge clock); #1;

    // -7 / 2 -> q=-3, r=-1 ; 7 / -2 -> q=-3, r=1
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bsy);
    check("div1_lat", lat, 64'd33);
    check("div1_lo",  lo_out, 64'hFFFF_FFFD);
    check("div1_hi",  hi_out, 64'hFFFF_FFFF);
    @(posedge clock); #1;
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, lat, bsy);
    check("div2_lo", lo_out, 64'hFFFF_FFFD);
    check("div2_hi", hi_out, 64'h0000_0001);
    @(posedge clock); #1;

    // Most negative / -1 wraps to itself with no flag
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bsy);
    check("div3_lo", lo_out, 64'h8000_0000);
    check("div3_hi", hi_out, 64'h0);
    check("div3_dz", div_zero, 64'h0);
    @(posedge clock); #1;

    // 3 * 5, then 9 / 0 keeps HI/LO
    run_op(1'b0, 32'd3, 32'd5, 1'b0, lat, bsy);
    check("mul3_lo", lo_out, 64'd15);
    @(posedge clock); #1;
    run_op(1'b1, 32'd9, 32'd0, 1'b0, lat, bsy);
    check("dz_lat",  lat, 64'd1);
    check("dz_done", done, 64'h1);
    check("dz_flag", div_zero, 64'h1);
    check("dz_hi",   hi_out, 64'h0);
    check("dz_lo",   lo_out, 64'd15);
    @(posedge clock); #1;
    check("dz_flag_pulse", div_zero, 64'h0);

    // 100 * -200 = -20000 with start re-pulsed mid-run
    run_op(1'b0, 32'd100, 32'hFFFF_FF38, 1'b1, lat, bsy);
    check("ign_lat", lat, 64'd33);
    check("ign_hi",  hi_out, 64'hFFFF_FFFF);
    check("ign_lo",  lo_out, 64'hFFFF_B1E0);
    @(posedge clock); #1;
    check("ign_single_done", done, 64'h0);
    check("ign_idle",        busy, 64'h0);

    // Reset 10 cycles into a divide aborts it
    op    = 1'b1;
    a_in  = 32'd1000;
    b_in  = 32'd7;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clock); #1;
    end
    #1 reset = 1'b0;
    #1;
    check("abort_hi",   hi_out, 64'h0);
    check("abort_lo",   lo_out, 64'h0);
    check("abort_busy", busy,   64'h0);
    check("abort_done", done,   64'h0);
    repeat (3) begin
      @(posedge clock); #1;
      check("abort_no_done", done, 64'h0);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    run_op(1'b0, 32'd2, 32'd3, 1'b0, lat, bsy);
    check("post_rst_lat", lat, 64'd33);
    check("post_rst_lo",  lo_out, 64'd6);
    check("post_rst_hi",  hi_out, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
